// File: rtl/dram_req_queue_if.sv
// rtl/dram_req_queue_if.sv - FD request/response and DRAM bridge handshake bundle
interface dram_req_queue_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_r_wb;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_r_wb;
  logic [63:0] resp_data;
  logic        C_in_valid;
  logic        C_r_wb;
  logic [7:0]  C_addr;
  logic [63:0] C_data_w;
  logic        C_out_valid;
  logic [63:0] C_data_r;

  modport slave (
    input  req_valid, req_r_wb, req_addr, req_wdata, C_out_valid, C_data_r,
    output req_ready, resp_valid, resp_r_wb, resp_data,
    output C_in_valid, C_r_wb, C_addr, C_data_w
  );

  modport master (
    output req_valid, req_r_wb, req_addr, req_wdata, C_out_valid, C_data_r,
    input  req_ready, resp_valid, resp_r_wb, resp_data,
    input  C_in_valid, C_r_wb, C_addr, C_data_w
  );
endinterface

// File: rtl/dram_req_queue.sv
// rtl/dram_req_queue.sv - in-order DRAM request FIFO issuing one request at a time to the bridge
module dram_req_queue #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  dram_req_queue_if.slave       bus,
  output logic [CW-1:0]         q_count,
  output logic                  proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 73;

  typedef enum logic [1:0] {Q_IDLE, Q_ISSUE, Q_WAIT, Q_RESP} state_t;

  state_t          state, state_n;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, empty, push, pop;
  logic [EW-1:0]   head;
  logic            resp_r_wb_q;
  logic [63:0]     resp_data_q;

  assign full          = (count == CW'(DEPTH));
  assign empty         = (count == '0);
  assign push          = bus.req_valid && !full;
  assign bus.req_ready = !full;
  assign head          = mem[rd_ptr];
  assign q_count       = count;

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      Q_IDLE:  if (!empty) state_n = Q_ISSUE;
      Q_ISSUE: state_n = Q_WAIT;
      Q_WAIT: begin
        if (bus.C_out_valid) begin
          pop     = 1'b1;
          state_n = Q_RESP;
        end
      end
      Q_RESP:  state_n = Q_IDLE;
      default: state_n = Q_IDLE;
    endcase
  end

  // Head stays put from issue to pop: rd_ptr only moves on pop, and a non-empty FIFO never writes the head slot.
  assign bus.C_in_valid = (state == Q_ISSUE);
  assign bus.C_r_wb     = (state != Q_IDLE) ? head[72]    : 1'b0;
  assign bus.C_addr     = (state != Q_IDLE) ? head[71:64] : 8'h00;
  assign bus.C_data_w   = (state != Q_IDLE) ? head[63:0]  : 64'h0;

  assign bus.resp_valid = (state == Q_RESP);
  assign bus.resp_r_wb  = (state == Q_RESP) ? resp_r_wb_q : 1'b0;
  assign bus.resp_data  = (state == Q_RESP) ? resp_data_q : 64'h0;

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= {bus.req_r_wb, bus.req_addr, bus.req_wdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= Q_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      proto_err   <= 1'b0;
      resp_r_wb_q <= 1'b0;
      resp_data_q <= 64'h0;
    end else begin
      state <= state_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A completion outside Q_WAIT is flagged and otherwise dropped.
      if (bus.C_out_valid && state != Q_WAIT) proto_err <= 1'b1;
      if (pop) begin
        resp_r_wb_q <= head[72];
        resp_data_q <= head[72] ? bus.C_data_r : 64'h0;
      end
    end
  end

endmodule

// File: tb/tb_dram_req_queue.sv
// tb/tb_dram_req_queue.sv - directed vector bench for dram_req_queue
module tb_dram_req_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] q_count;
  logic       proto_err;
  int         n_vec  = 0;
  int         n_miss = 0;

  dram_req_queue_if bus();

  dram_req_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .q_count   (q_count),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic        rwb;
    logic [7:0]  addr;
    logic        cov;
    logic [63:0] dr;
    logic        e_rdy;
    logic        e_civ;
    logic        chk_head;
    logic        e_crwb;
    logic [7:0]  e_caddr;
    logic        e_rv;
    logic        e_rrwb;
    logic [63:0] e_rdata;
    logic [2:0]  e_cnt;
    logic        e_perr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rv, logic rwb, logic [7:0] addr, logic cov, logic [63:0] dr,
                              logic e_rdy, logic e_civ, logic chk_head, logic e_crwb, logic [7:0] e_caddr,
                              logic e_rv, logic e_rrwb, logic [63:0] e_rdata, logic [2:0] e_cnt, logic e_perr);
    vec_t v;
    v.rv = rv; v.rwb = rwb; v.addr = addr; v.cov = cov; v.dr = dr;
    v.e_rdy = e_rdy; v.e_civ = e_civ; v.chk_head = chk_head; v.e_crwb = e_crwb; v.e_caddr = e_caddr;
    v.e_rv = e_rv; v.e_rrwb = e_rrwb; v.e_rdata = e_rdata; v.e_cnt = e_cnt; v.e_perr = e_perr;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic rv, logic rwb, logic [7:0] addr, logic [63:0] wd, logic cov, logic [63:0] dr);
    bus.req_valid   = rv;
    bus.req_r_wb    = rwb;
    bus.req_addr    = addr;
    bus.req_wdata   = wd;
    bus.C_out_valid = cov;
    bus.C_data_r    = dr;
  endtask

  task automatic step(logic rv, logic rwb, logic [7:0] addr, logic [63:0] wd, logic cov, logic [63:0] dr);
    @(negedge clk);
    drive(rv, rwb, addr, wd, cov, dr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 8'h00, 64'h0, 0, 64'h0);

    // rd, rwb, addr, cov, dr | rdy, civ, chk_head, crwb, caddr, rvalid, rrwb, rdata, cnt, perr
    tbl.push_back(mk(1,1,8'h12,0,64'h0,                   1,0,1,0,8'h00, 0,0,64'h0,                   3'd1,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   1,1,1,1,8'h12, 0,0,64'h0,                   3'd1,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   1,0,1,1,8'h12, 0,0,64'h0,                   3'd1,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   1,0,1,1,8'h12, 0,0,64'h0,                   3'd1,0));
    tbl.push_back(mk(0,0,8'h00,1,64'hDEAD_BEEF_0000_0001, 1,0,0,0,8'h00, 1,1,64'hDEAD_BEEF_0000_0001, 3'd0,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   1,0,1,0,8'h00, 0,0,64'h0,                   3'd0,0));
    tbl.push_back(mk(1,1,8'h00,0,64'h0,                   1,0,1,0,8'h00, 0,0,64'h0,                   3'd1,0));
    tbl.push_back(mk(1,1,8'h01,0,64'h0,                   1,1,1,1,8'h00, 0,0,64'h0,                   3'd2,0));
    tbl.push_back(mk(1,1,8'h02,0,64'h0,                   1,0,1,1,8'h00, 0,0,64'h0,                   3'd3,0));
    tbl.push_back(mk(1,1,8'h03,0,64'h0,                   0,0,1,1,8'h00, 0,0,64'h0,                   3'd4,0));
    tbl.push_back(mk(1,1,8'h04,0,64'h0,                   0,0,1,1,8'h00, 0,0,64'h0,                   3'd4,0));
    tbl.push_back(mk(1,1,8'h04,1,64'hD000_0000_0000_0000, 1,0,1,1,8'h01, 1,1,64'hD000_0000_0000_0000, 3'd3,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   1,0,1,0,8'h00, 0,0,64'h0,                   3'd3,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   1,1,1,1,8'h01, 0,0,64'h0,                   3'd3,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   1,0,1,1,8'h01, 0,0,64'h0,                   3'd3,0));
    tbl.push_back(mk(1,1,8'h04,1,64'hD000_0000_0000_0001, 1,0,1,1,8'h02, 1,1,64'hD000_0000_0000_0001, 3'd3,0));
    tbl.push_back(mk(1,1,8'h05,0,64'h0,                   0,0,1,0,8'h00, 0,0,64'h0,                   3'd4,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   0,1,1,1,8'h02, 0,0,64'h0,                   3'd4,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   0,0,1,1,8'h02, 0,0,64'h0,                   3'd4,0));
    tbl.push_back(mk(0,0,8'h00,1,64'hD000_0000_0000_0002, 1,0,1,1,8'h03, 1,1,64'hD000_0000_0000_0002, 3'd3,0));
    tbl.push_back(mk(1,1,8'h06,0,64'h0,                   0,0,1,0,8'h00, 0,0,64'h0,                   3'd4,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   0,1,1,1,8'h03, 0,0,64'h0,                   3'd4,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   0,0,1,1,8'h03, 0,0,64'h0,                   3'd4,0));
    tbl.push_back(mk(0,0,8'h00,1,64'hD000_0000_0000_0003, 1,0,1,1,8'h04, 1,1,64'hD000_0000_0000_0003, 3'd3,0));
    tbl.push_back(mk(1,1,8'h07,0,64'h0,                   0,0,1,0,8'h00, 0,0,64'h0,                   3'd4,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   0,1,1,1,8'h04, 0,0,64'h0,                   3'd4,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   0,0,1,1,8'h04, 0,0,64'h0,                   3'd4,0));
    tbl.push_back(mk(0,0,8'h00,1,64'hD000_0000_0000_0004, 1,0,1,1,8'h05, 1,1,64'hD000_0000_0000_0004, 3'd3,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   1,0,1,0,8'h00, 0,0,64'h0,                   3'd3,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   1,1,1,1,8'h05, 0,0,64'h0,                   3'd3,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   1,0,1,1,8'h05, 0,0,64'h0,                   3'd3,0));
    tbl.push_back(mk(0,0,8'h00,1,64'hD000_0000_0000_0005, 1,0,1,1,8'h06, 1,1,64'hD000_0000_0000_0005, 3'd2,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   1,0,1,0,8'h00, 0,0,64'h0,                   3'd2,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   1,1,1,1,8'h06, 0,0,64'h0,                   3'd2,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   1,0,1,1,8'h06, 0,0,64'h0,                   3'd2,0));
    tbl.push_back(mk(0,0,8'h00,1,64'hD000_0000_0000_0006, 1,0,1,1,8'h07, 1,1,64'hD000_0000_0000_0006, 3'd1,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   1,0,1,0,8'h00, 0,0,64'h0,                   3'd1,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   1,1,1,1,8'h07, 0,0,64'h0,                   3'd1,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   1,0,1,1,8'h07, 0,0,64'h0,                   3'd1,0));
    tbl.push_back(mk(0,0,8'h00,1,64'hD000_0000_0000_0007, 1,0,0,0,8'h00, 1,1,64'hD000_0000_0000_0007, 3'd0,0));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   1,0,1,0,8'h00, 0,0,64'h0,                   3'd0,0));
    // stray completion while idle
    tbl.push_back(mk(0,0,8'h00,1,64'hFFFF_FFFF_FFFF_FFFF, 1,0,1,0,8'h00, 0,0,64'h0,                   3'd0,1));
    tbl.push_back(mk(0,0,8'h00,0,64'h0,                   1,0,1,0,8'h00, 0,0,64'h0,                   3'd0,1));

    // reset state while rst is held
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_c_in_valid", bus.C_in_valid, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_proto_err", proto_err, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].rv, tbl[i].rwb, tbl[i].addr, 64'h0, tbl[i].cov, tbl[i].dr);
      chk($sformatf("v%0d_req_ready", i), bus.req_ready, tbl[i].e_rdy);
      chk($sformatf("v%0d_c_in_valid", i), bus.C_in_valid, tbl[i].e_civ);
      if (tbl[i].chk_head) begin
        chk($sformatf("v%0d_c_r_wb", i), bus.C_r_wb, tbl[i].e_crwb);
        chk($sformatf("v%0d_c_addr", i), bus.C_addr, tbl[i].e_caddr);
      end
      chk($sformatf("v%0d_resp_valid", i), bus.resp_valid, tbl[i].e_rv);
      chk($sformatf("v%0d_resp_r_wb", i), bus.resp_r_wb, tbl[i].e_rrwb);
      chk($sformatf("v%0d_resp_data", i), bus.resp_data, tbl[i].e_rdata);
      chk($sformatf("v%0d_q_count", i), q_count, tbl[i].e_cnt);
      chk($sformatf("v%0d_proto_err", i), proto_err, tbl[i].e_perr);
    end

    // write held across a 20-cycle bridge stall
    step(1, 0, 8'h05, 64'hA5A5_A5A5_A5A5_A5A5, 0, 64'h0);
    step(0, 0, 8'h00, 64'h0, 0, 64'h0);
    chk("wr_issue_civ", bus.C_in_valid, 1);
    chk("wr_issue_addr", bus.C_addr, 8'h05);
    chk("wr_issue_rwb", bus.C_r_wb, 0);
    chk("wr_issue_data", bus.C_data_w, 64'hA5A5_A5A5_A5A5_A5A5);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 8'h00, 64'h0, 0, 64'h0);
      chk($sformatf("wr_hold%0d_data", k), bus.C_data_w, 64'hA5A5_A5A5_A5A5_A5A5);
      chk($sformatf("wr_hold%0d_civ", k), bus.C_in_valid, 0);
      chk($sformatf("wr_hold%0d_addr", k), bus.C_addr, 8'h05);
    end
    step(0, 0, 8'h00, 64'h0, 1, 64'h1234_5678_9ABC_DEF0);
    chk("wr_resp_valid", bus.resp_valid, 1);
    chk("wr_resp_data", bus.resp_data, 64'h0);
    chk("wr_resp_rwb", bus.resp_r_wb, 0);
    chk("wr_resp_count", q_count, 0);
    chk("wr_perr_sticky", proto_err, 1);
    step(0, 0, 8'h00, 64'h0, 0, 64'h0);
    chk("wr_after_resp_valid", bus.resp_valid, 0);

    // reset in Q_WAIT with three queued
    step(1, 1, 8'h30, 64'h0, 0, 64'h0);
    step(1, 1, 8'h31, 64'h0, 0, 64'h0);
    step(1, 1, 8'h32, 64'h0, 0, 64'h0);
    chk("pre_rst_count", q_count, 3);
    chk("pre_rst_addr", bus.C_addr, 8'h30);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_count", q_count, 0);
    chk("mid_rst_addr", bus.C_addr, 8'h00);
    chk("mid_rst_rwb", bus.C_r_wb, 0);
    chk("mid_rst_perr", proto_err, 0);
    chk("mid_rst_ready", bus.req_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_count", q_count, 0);
    @(negedge clk);
    drive(0, 0, 8'h00, 64'h0, 0, 64'h0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 8'h00, 64'h0, 0, 64'h0);
      chk($sformatf("post_rst%0d_civ", k), bus.C_in_valid, 0);
      chk($sformatf("post_rst%0d_resp", k), bus.resp_valid, 0);
    end
    step(1, 1, 8'h44, 64'h0, 0, 64'h0);
    chk("post_rst_push_count", q_count, 1);
    step(0, 0, 8'h00, 64'h0, 0, 64'h0);
    chk("post_rst_issue_civ", bus.C_in_valid, 1);
    chk("post_rst_issue_addr", bus.C_addr, 8'h44);
    step(0, 0, 8'h00, 64'h0, 0, 64'h0);
    step(0, 0, 8'h00, 64'h0, 1, 64'h0000_0000_0000_0044);
    chk("post_rst_resp_valid", bus.resp_valid, 1);
    chk("post_rst_resp_data", bus.resp_data, 64'h0000_0000_0000_0044);
    chk("post_rst_resp_rwb", bus.resp_r_wb, 1);
    chk("post_rst_perr", proto_err, 0);
    step(0, 0, 8'h00, 64'h0, 0, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
